// File: rtl/mem_dump_reader.sv
// Debug readback engine: reads a word range from a fixed-latency BRAM and streams it LSB-first as bytes.
// Define DUMP_CHECKSUM_EN to append a running-XOR trailer byte after the data bytes.
module mem_dump_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [ADDR_WIDTH:0]   word_count_in,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_en_out,
    input  logic [31:0]           mem_data_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid_out,
    input  logic                  byte_ready_in,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = 1;
    localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND,
`ifdef DUMP_CHECKSUM_EN
        S_TRAIL,
`endif
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [ADDR_WIDTH-1:0] r_nextAddr;
    logic                  r_memEn;
    logic [31:0]           r_shift;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [1:0]            r_byteIdx;
    logic [WAIT_W-1:0]     r_wait;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic w_xfer;
    assign w_xfer = r_valid && byte_ready_in;

    // byte_out is the low byte of the shift register, so it stays put while the sink stalls
    assign mem_addr_out   = r_memAddr;
    assign mem_en_out     = r_memEn;
    assign byte_out       = r_shift[7:0];
    assign byte_valid_out = r_valid;
    assign busy_out       = r_busy;
    assign done_out       = r_done;

    always_ff @(posedge clk_100mhz) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_memAddr   <= '0;
            r_nextAddr  <= '0;
            r_memEn     <= 1'b0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_byteIdx   <= '0;
            r_wait      <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_memEn <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_remaining <= word_count_in;
                        r_byteIdx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_csum      <= '0;
`endif
                        if (word_count_in == '0) begin
`ifdef DUMP_CHECKSUM_EN
                            r_shift <= '0;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_TRAIL;
`else
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_memAddr  <= base_addr_in;
                            r_nextAddr <= base_addr_in + ADDR_ONE;
                            r_memEn    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait  <= WAIT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_shift <= mem_data_in;
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_wait <= r_wait - WAIT_ONE;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
`ifdef DUMP_CHECKSUM_EN
                        r_csum <= r_csum ^ r_shift[7:0];
`endif
                        if (r_byteIdx != 2'd3) begin
                            r_shift   <= {8'h00, r_shift[31:8]};
                            r_byteIdx <= r_byteIdx + 2'd1;
                        end else begin
                            r_byteIdx   <= '0;
                            r_remaining <= r_remaining - COUNT_ONE;
                            if (r_remaining != COUNT_ONE) begin
                                r_valid    <= 1'b0;
                                r_memAddr  <= r_nextAddr;
                                r_nextAddr <= r_nextAddr + ADDR_ONE;
                                r_memEn    <= 1'b1;
                                r_state    <= S_ISSUE;
                            end else begin
`ifdef DUMP_CHECKSUM_EN
                                r_shift <= {24'h000000, r_csum ^ r_shift[7:0]};
                                r_state <= S_TRAIL;
`else
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_TRAIL: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a 2-cycle BRAM model; honours DUMP_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_mem_dump_reader;

    localparam int AW = 12;

    logic          clk_100mhz = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] base_addr_in;
    logic [AW:0]   word_count_in;
    logic [AW-1:0] mem_addr_out;
    logic          mem_en_out;
    logic [31:0]   mem_data_in;
    logic [7:0]    byte_out;
    logic          byte_valid_out;
    logic          byte_ready_in;
    logic          busy_out;
    logic          done_out;

    mem_dump_reader #(.ADDR_WIDTH(AW), .RD_LATENCY(2)) dut (
        .clk_100mhz     (clk_100mhz),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .base_addr_in   (base_addr_in),
        .word_count_in  (word_count_in),
        .mem_addr_out   (mem_addr_out),
        .mem_en_out     (mem_en_out),
        .mem_data_in    (mem_data_in),
        .byte_out       (byte_out),
        .byte_valid_out (byte_valid_out),
        .byte_ready_in  (byte_ready_in),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Two-stage read pipeline: address sampled on en, data valid two edges later
    logic [31:0] mem [0:4095];
    logic [31:0] memStage = 32'h0;
    initial mem_data_in = 32'h0;
    always @(posedge clk_100mhz) begin
        if (mem_en_out) memStage <= mem[mem_addr_out];
        mem_data_in <= memStage;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]    gotQ[$];
    logic [7:0]    expQ[$];
    int            byteCycQ[$];
    logic [AW-1:0] addrQ[$];
    int            enCount;
    int            doneCycle;
    int            stallErrors;
    int            stallCount;
    logic [63:0]   busyBits;
    logic [63:0]   enBits;
    logic [23:0]   abortSnap;

    function automatic logic [23:0] snapOutputs();
        return {mem_addr_out, mem_en_out, byte_out, byte_valid_out, busy_out, done_out};
    endfunction

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic compareBytes(input string tag);
        checkOutput({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < gotQ.size()) ? 64'(gotQ[i]) : 64'hFFFF, 64'(expQ[i]));
        end
    endtask

    // Runs one dump from cycle 0 (start sampled) until done_out, the cycle budget, or an abort
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] count,
                                 input int readyMode, input int injectCyc,
                                 input int abortAt, input int maxCyc);
        int         cyc;
        bit         finished;
        bit         prevStall;
        logic [7:0] prevByte;
        gotQ.delete();
        byteCycQ.delete();
        addrQ.delete();
        enCount     = 0;
        doneCycle   = -1;
        stallErrors = 0;
        stallCount  = 0;
        busyBits    = '0;
        enBits      = '0;
        abortSnap   = '1;
        prevStall   = 1'b0;
        prevByte    = 8'h00;
        base_addr_in  = base;
        word_count_in = count;
        cyc      = 0;
        finished = 1'b0;
        while (!finished) begin
            if (cyc < 64) begin
                busyBits[cyc] = busy_out;
                enBits[cyc]   = mem_en_out;
            end
            if (mem_en_out) begin
                enCount++;
                addrQ.push_back(mem_addr_out);
            end
            if (done_out) doneCycle = cyc;
            if (prevStall && (!byte_valid_out || byte_out !== prevByte)) stallErrors++;
            byte_ready_in = (readyMode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            start_in = (cyc == 0) || (cyc == injectCyc);
            if (cyc == injectCyc) begin
                base_addr_in  = base ^ 12'hABC;
                word_count_in = 13'd5;
            end
            if (abortAt >= 0 && byte_valid_out && gotQ.size() == abortAt) begin
                rst_in = 1'b0;
                tick();
                abortSnap = snapOutputs();
                rst_in    = 1'b1;
                finished  = 1'b1;
            end else begin
                if (byte_valid_out && byte_ready_in) begin
                    gotQ.push_back(byte_out);
                    byteCycQ.push_back(cyc);
                end
                if (byte_valid_out && !byte_ready_in) stallCount++;
                prevStall = byte_valid_out && !byte_ready_in;
                prevByte  = byte_out;
                if (doneCycle >= 0 || cyc >= maxCyc) finished = 1'b1;
                tick();
                cyc++;
            end
        end
        start_in      = 1'b0;
        byte_ready_in = 1'b1;
    endtask

    initial begin
        logic [31:0] wv;
        logic [7:0]  x;
        logic [11:0] a;
        int          lateDone;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst_in        = 1'b0;
        start_in      = 1'b0;
        base_addr_in  = '0;
        word_count_in = '0;
        byte_ready_in = 1'b1;
        repeat (3) tick();
        checkOutput("reset_outputs", 64'(snapOutputs()), 64'h0);
        rst_in = 1'b1;
        tick();
        checkOutput("idle_outputs", 64'(snapOutputs()), 64'h0);

        $display("[TB] single word 0xDEADBEEF at 0x010");
        mem[12'h010] = 32'hDEADBEEF;
        applyStimulus(12'h010, 13'd1, 0, -1, -1, 200);
        expQ = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef DUMP_CHECKSUM_EN
        expQ.push_back(8'h22);
`endif
        compareBytes("t1");
        checkOutput("t1_first_byte_cycle", 64'(byteCycQ.size() > 0 ? byteCycQ[0] : -1), 64'(4));
        checkOutput("t1_fourth_byte_cycle", 64'(byteCycQ.size() > 3 ? byteCycQ[3] : -1), 64'(7));
        checkOutput("t1_en_cycles", enBits, 64'h2);
        checkOutput("t1_addr", 64'(addrQ.size() > 0 ? addrQ[0] : 12'hBAD), 64'h010);
`ifdef DUMP_CHECKSUM_EN
        checkOutput("t1_done_cycle", 64'(doneCycle), 64'(9));
        checkOutput("t1_busy_cycles", busyBits, 64'h1FE);
`else
        checkOutput("t1_done_cycle", 64'(doneCycle), 64'(8));
        checkOutput("t1_busy_cycles", busyBits, 64'hFE);
`endif
        tick();
        checkOutput("t1_after_done", 64'({busy_out, done_out}), 64'h0);
        tick();

        $display("[TB] address wrap 0xFFF -> 0x000");
        mem[12'hFFF] = 32'h11223344;
        mem[12'h000] = 32'h55667788;
        applyStimulus(12'hFFF, 13'd2, 0, -1, -1, 200);
        expQ = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
`ifdef DUMP_CHECKSUM_EN
        expQ.push_back(8'h88);
        checkOutput("t2_done_cycle", 64'(doneCycle), 64'(16));
`else
        checkOutput("t2_done_cycle", 64'(doneCycle), 64'(15));
`endif
        compareBytes("t2");
        checkOutput("t2_en_count", 64'(enCount), 64'(2));
        checkOutput("t2_addr0", 64'(addrQ.size() > 0 ? addrQ[0] : 12'hBAD), 64'hFFF);
        checkOutput("t2_addr1", 64'(addrQ.size() > 1 ? addrQ[1] : 12'hBAD), 64'h000);
        checkOutput("t2_fifth_byte_cycle", 64'(byteCycQ.size() > 4 ? byteCycQ[4] : -1), 64'(11));
        tick();
        tick();

        $display("[TB] random backpressure, 3 words, ignored start mid-dump");
        mem[12'h200] = 32'hA1B2C3D4;
        mem[12'h201] = 32'h0F1E2D3C;
        mem[12'h202] = 32'h99887766;
        applyStimulus(12'h200, 13'd3, 1, 5, -1, 600);
        expQ.delete();
        x = 8'h00;
        for (int w = 0; w < 3; w++) begin
            a  = 12'h200 + 12'(w);
            wv = mem[a];
            for (int b = 0; b < 4; b++) begin
                expQ.push_back(wv[8*b +: 8]);
                x = x ^ wv[8*b +: 8];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        expQ.push_back(x);
`endif
        compareBytes("t3");
        checkOutput("t3_done_seen", 64'(doneCycle >= 0), 64'(1));
        checkOutput("t3_stall_stable", 64'(stallErrors), 64'(0));
        checkOutput("t3_en_count", 64'(enCount), 64'(3));
        checkOutput("t3_addr2", 64'(addrQ.size() > 2 ? addrQ[2] : 12'hBAD), 64'h202);
        $display("[TB] stalled cycles seen: %0d", stallCount);
        tick();
        tick();

        $display("[TB] zero-length dump");
        applyStimulus(12'h123, 13'd0, 0, -1, -1, 50);
`ifdef DUMP_CHECKSUM_EN
        expQ = '{8'h00};
        checkOutput("t4_done_cycle", 64'(doneCycle), 64'(2));
`else
        expQ.delete();
        checkOutput("t4_done_cycle", 64'(doneCycle), 64'(1));
`endif
        compareBytes("t4");
        checkOutput("t4_en_count", 64'(enCount), 64'(0));
        checkOutput("t4_addr_held", 64'(mem_addr_out), 64'h202);
        tick();
        tick();

        $display("[TB] reset during the second byte of word 1");
        mem[12'h100] = 32'hCAFEF00D;
        mem[12'h101] = 32'h13579BDF;
        mem[12'h102] = 32'h2468ACE0;
        mem[12'h103] = 32'h0BADC0DE;
        applyStimulus(12'h100, 13'd4, 0, -1, 5, 300);
        checkOutput("t5_outputs_after_reset", 64'(abortSnap), 64'h0);
        checkOutput("t5_bytes_before_abort", 64'(gotQ.size()), 64'(5));
        checkOutput("t5_no_done_before", 64'(doneCycle), 64'(-1));
        lateDone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_out || busy_out || byte_valid_out) lateDone++;
            tick();
        end
        checkOutput("t5_quiet_after_reset", 64'(lateDone), 64'(0));
        applyStimulus(12'h101, 13'd1, 0, -1, -1, 200);
        expQ = '{8'hDF, 8'h9B, 8'h57, 8'h13};
`ifdef DUMP_CHECKSUM_EN
        expQ.push_back(8'h00);
`endif
        compareBytes("t5_restart");
        checkOutput("t5_restart_addr", 64'(addrQ.size() > 0 ? addrQ[0] : 12'hBAD), 64'h101);
        tick();
        tick();

        $display("[TB] word 0x01020304 with start pulsed while busy");
        mem[12'h300] = 32'h01020304;
        applyStimulus(12'h300, 13'd1, 0, 3, -1, 200);
        expQ = '{8'h04, 8'h03, 8'h02, 8'h01};
`ifdef DUMP_CHECKSUM_EN
        expQ.push_back(8'h04);
        checkOutput("t6_done_cycle", 64'(doneCycle), 64'(9));
`else
        checkOutput("t6_done_cycle", 64'(doneCycle), 64'(8));
`endif
        compareBytes("t6");
        checkOutput("t6_en_count", 64'(enCount), 64'(1));
        tick();
        repeat (4) tick();
        checkOutput("t6_no_requeued_start", 64'({busy_out, mem_en_out, done_out}), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Debug readback engine for the processor's data memory. On command it reads a contiguous range of 32-bit words from a single-port BRAM with fixed read latency. It then serializes each word into bytes, least significant byte first, on a valid/ready byte stream. A UART transmitter or ILA capture sits downstream. It is the read-side counterpart of the core's store path and dumps program results after execution.

## Interface
Parameters:
- ADDR_WIDTH, 12, word-address width of the memory (depth 2^ADDR_WIDTH).
- RD_LATENCY, 2, cycles from address sampled to `mem_data_in` valid (2 = HIGH_PERFORMANCE BRAM).

Ports:
- clk_100mhz  input  1  system clock; all logic on rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- start_in  input  1  begin dump; sampled only in IDLE.
- base_addr_in  input  ADDR_WIDTH  first word address, latched on accepted start.
- word_count_in  input  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH, latched on accepted start.
- mem_addr_out  output  ADDR_WIDTH  BRAM word address.
- mem_en_out  output  1  read strobe, one cycle per word.
- mem_data_in  input  32  BRAM read data.
- byte_out  output  8  stream data.
- byte_valid_out  output  1  stream valid.
- byte_ready_in  input  1  stream ready from sink.
- busy_out  output  1  dump in progress.
- done_out  output  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: if `start_in`, latch base/count, clear the byte counter and checksum. Go to DONE if count is 0, else ISSUE.
  - ISSUE (1 cycle): drive `mem_addr_out` = current address and `mem_en_out` = 1. Go to WAIT.
  - WAIT (RD_LATENCY cycles, down-counter): on its last cycle, capture `mem_data_in` into a 32-bit shift register. Go to SEND.
  - SEND: present shift[7:0]. On handshake, shift right 8; after 4th byte, decrement words remaining and increment address.
    - Words remaining → ISSUE.
    - Otherwise → TRAIL (checksum build) or DONE.
  - DONE (1 cycle): `done_out` = 1 → IDLE.
- Handshake: transfer iff `byte_valid_out && byte_ready_in`. While valid and not ready, `byte_out` holds stable and valid stays high. Valid never drops without a transfer.
- Address increments modulo 2^ADDR_WIDTH: base 0xFFF with count 2 reads 0xFFF then 0x000.
- `busy_out` = 1 in ISSUE, WAIT, SEND, TRAIL; 0 in IDLE and DONE.
- `start_in` outside IDLE is ignored; no queuing.
- Latched base/count are unaffected by input changes after acceptance.
- `mem_addr_out` holds its last value when `mem_en_out` = 0.
- Reset mid-dump: next cycle in IDLE, every output at its reset value, no `done_out`. Partial output is discarded.

## Timing
- Reset values: `mem_addr_out` 0, `mem_en_out` 0, `byte_out` 0, `byte_valid_out` 0, `busy_out` 0, `done_out` 0.
- Start sampled in cycle 0 → ISSUE in cycle 1 → data captured end of cycle 1+RD_LATENCY → first `byte_valid_out` in cycle RD_LATENCY+2 (cycle 4 at default).
- Ready held high: 4 bytes on consecutive cycles, next ISSUE the cycle after the 4th byte. Throughput is one word per RD_LATENCY+5 cycles (7 at default).
- `done_out` rises the cycle after the final transfer.
- Count 0: `done_out` in cycle 1, no memory access, no bytes.
- Backpressure stalls only SEND/TRAIL. The memory is not re-read during a stall.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - A running XOR is kept over every byte transferred.
  - After the last data byte, TRAIL presents that XOR as one extra byte, with the same handshake rules, then → DONE.
  - Count 0 still sends the trailer 0x00, then → DONE.
- Not defined: no TRAIL state and no checksum register. SEND → DONE directly.

## Test plan
- Reset, then memory[0x010] = 0xDEADBEEF, base 0x010, count 1, ready high:
  - bytes EF, BE, AD, DE on cycles 4–7.
  - `mem_en_out` high only in cycle 1.
  - `done_out` in cycle 8, `busy_out` high cycles 1–7.
- Memory[0xFFF] = 0x11223344, memory[0x000] = 0x55667788, base 0xFFF, count 2:
  - addresses 0xFFF then 0x000.
  - bytes 44 33 22 11 88 77 66 55.
- Ready toggled with a pseudo-random pattern over a 3-word dump:
  - `byte_out` stable during every stall.
  - 12 bytes in order, no duplicates or drops.
  - exactly 3 `mem_en_out` pulses.
- Count 0: `done_out` in cycle 1, zero bytes without the macro. With `DUMP_CHECKSUM_EN`, exactly one byte 0x00 then `done_out`.
- Drive `rst_in` = 0 during the 2nd byte of word 1 of a 4-word dump:
  - all outputs at reset values next cycle.
  - no `done_out`.
  - a new start then dumps correctly from byte 0.
- With `DUMP_CHECKSUM_EN`, data 0x01020304: trailer byte 0x04 (01^02^03^04) follows the four data bytes. A `start_in` during busy is ignored.
